tt_um_vlsi_serial_sub: RTL and testbench
========================================

TT_UM_VLSI_SERIAL_SUB -- requirements
Module: tt_um_vlsi_serial_sub

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is named clk and the reset port is named rst_n.
REQ-002 The block SHALL expose these ports, one per line as name / direction / width / meaning:
- clk  input  1  rising-edge clock
- rst_n  input  1  async active-low reset
- ena  input  1  powered indication, ignored
- ui_in  input  8  [3:0] minuend A, [7:4] subtrahend B
- uio_in  input  8  [0] start (level, sampled); [7:1] unused
- uo_out  output  8  [3:0] difference D, [4] borrow, [5] busy, [6] done, [7] zero
- uio_out  output  8  constant 0
- uio_oe  output  8  constant 0 (all uio pins are inputs)
REQ-003 Unused inputs (ena, uio_in[7:1]) SHALL be consumed without affecting behaviour.

Function
REQ-004 The block SHALL compute D = (A - B) mod 16 and borrow = (A < B), bit-serially, LSB first, one bit per clock, using a full subtractor built from two half subtractors.
REQ-005 Per-bit arithmetic: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin); the initial bin is 0.
REQ-006 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-007 In IDLE, with start=1 at a rising edge, the block SHALL load A and B into 4-bit shift registers, clear the borrow flop and bit counter, and enter SHIFT; with start=0 it SHALL remain in IDLE.
REQ-008 In SHIFT, each edge SHALL process the current LSBs, shift the difference bit into a result shift register from the MSB side, update the borrow flop, and increment the 2-bit counter.
REQ-009 On the edge that processes bit 3, the block SHALL enter DONE and update the output registers for D, borrow and zero.
REQ-010 DONE SHALL last exactly one cycle, after which the block returns to IDLE unconditionally.
REQ-011 busy SHALL be 1 exactly while in SHIFT; done SHALL be 1 exactly while in DONE.
REQ-012 Latency: start sampled at edge k gives busy=1 after edges k..k+3, done=1 after edge k+4, and done=0 after edge k+5.
REQ-013 D, borrow and zero SHALL be registered, SHALL hold their values through IDLE and SHIFT, and SHALL change only at the DONE-entry edge.
REQ-014 zero SHALL equal 1 when the final D == 0, independent of borrow.
REQ-015 start SHALL be ignored in SHIFT and DONE; ui_in changes after the load edge SHALL NOT affect the result.
REQ-016 If start is held high continuously, a new operation SHALL load on the first IDLE edge, giving back-to-back operations every 6 cycles.
REQ-017 All outputs SHALL come from registers or constants, with no combinational path from inputs to uo_out.

Reset
REQ-018 When rst_n=0, the block SHALL immediately force state=IDLE and clear all shift registers, the counter, the borrow flop and the output registers, so uo_out=8'h00.
REQ-019 Reset asserted mid-SHIFT SHALL abort the operation with no partial result visible; after release, the block SHALL wait in IDLE for start.
REQ-020 Reset release SHALL be clean at any clock phase; the first active edge after release is treated as an ordinary IDLE edge.

Verification
REQ-021 A=9, B=3, start pulse -> done after 5 cycles; D=6, borrow=0, zero=0; uo_out=8'h46 during DONE.
REQ-022 A=3, B=9 -> D=10 (4'hA), borrow=1, zero=0; with uo_out held at 8'h1A after DONE.
REQ-023 A=5, B=5 -> D=0, borrow=0, zero=1; A=0, B=15 -> D=1, borrow=1.
REQ-024 Start A=9, B=3; change ui_in to A=1, B=2 and pulse start during SHIFT -> result is still D=6, and no second operation begins until IDLE.
REQ-025 Start A=12, B=4; assert rst_n=0 after 2 SHIFT cycles -> uo_out=0 immediately; after release, no done appears without a new start.
REQ-026 Exhaustive check of all 256 A/B pairs with start held high -> every result matches (A-B) mod 16 and borrow, one done every 6 cycles, and uio_oe=uio_out=0 throughout.

Source files
------------

// File: rtl/tt_um_vlsi_serial_sub.sv
// Bit-serial 4-bit subtractor: computes D = (A - B) mod 16 and borrow = (A < B)
// one bit per clock, LSB first, with a full subtractor made of two half
// subtractors. All uo_out bits come from flops or from a decode of the state flops.
`timescale 1ns/1ps

// Half subtractor: d = a - b, bout set when a borrow is needed.
module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);
  assign d    = a ^ b;
  assign bout = ~a & b;
endmodule

module tt_um_vlsi_serial_sub (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] a_sr, b_sr, res_sr;
  logic [3:0] d_q;
  logic [1:0] cnt;
  logic       bin_q, borrow_q, zero_q;
  logic       busy, done;
  logic       start;
  logic       d1, b1, b2, d_bit, bout;
  logic [3:0] res_next;

  // Powered indication and spare uio inputs have no function.
  logic unused_inputs;
  assign unused_inputs = ^{ena, uio_in[7:1]};

  assign start = uio_in[0];

  // Full subtractor: A - B, then subtract the incoming borrow.
  half_sub u_hs_ab  (.a(a_sr[0]), .b(b_sr[0]), .d(d1),    .bout(b1));
  half_sub u_hs_bin (.a(d1),      .b(bin_q),   .d(d_bit), .bout(b2));
  assign bout = b1 | b2;

  // Difference bits enter from the MSB side, so bit 0 lands in res[0] after four shifts.
  assign res_next = {d_bit, res_sr[3:1]};

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: DONE lasts one cycle, start only matters in IDLE.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the state flops only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands, shift one bit per SHIFT edge, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      bin_q    <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= ui_in[3:0];
            b_sr   <= ui_in[7:4];
            res_sr <= '0;
            cnt    <= '0;
            bin_q  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[3:1]};
          b_sr   <= {1'b0, b_sr[3:1]};
          res_sr <= res_next;
          bin_q  <= bout;
          cnt    <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            d_q      <= res_next;
            borrow_q <= bout;
            zero_q   <= (res_next == 4'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = {zero_q, done, busy, borrow_q, d_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_vlsi_serial_sub.sv
// Self-checking bench for tt_um_vlsi_serial_sub: vector table of hand-computed
// results, hand-written sequences for start-during-SHIFT and mid-SHIFT reset,
// and a sweep of all 256 operand pairs with start held high.
`timescale 1ns/1ps

module tb_tt_um_vlsi_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench model of the held result registers: {zero, borrow, D}.
  logic [3:0] held_d;
  logic       held_b;
  logic       held_z;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       borrow;
    logic       zero;
  } vec_t;

  vec_t vecs[10];

  tt_um_vlsi_serial_sub dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mk(input logic dn, input logic bz);
    return {held_z, dn, bz, held_b, held_d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    check("uio_oe", uio_oe, 8'h00);
    check("uio_out", uio_out, 8'h00);
  endtask

  // One full operation: load edge, four SHIFT edges, DONE-exit edge.
  // With keep_start the start bit stays high throughout.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic bw, input logic z,
                        input bit keep_start, input string tag);
    ui_in     = {b, a};
    uio_in[0] = 1'b1;
    tick();                                   // edge k: load
    if (!keep_start) uio_in[0] = 1'b0;
    check({tag, " busy k"}, uo_out, mk(1'b0, 1'b1));
    for (int i = 1; i <= 3; i++) begin
      tick();                                 // edges k+1..k+3
      check({tag, " busy"}, uo_out, mk(1'b0, 1'b1));
    end
    tick();                                   // edge k+4: enter DONE
    held_d = d; held_b = bw; held_z = z;
    check({tag, " done"}, uo_out, mk(1'b1, 1'b0));
    tick();                                   // edge k+5: back to IDLE
    check({tag, " idle"}, uo_out, mk(1'b0, 1'b0));
  endtask

  initial begin
    vecs[0] = '{a: 4'd9,  b: 4'd3,  d: 4'h6, borrow: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd9,  d: 4'hA, borrow: 1'b1, zero: 1'b0};
    vecs[2] = '{a: 4'd5,  b: 4'd5,  d: 4'h0, borrow: 1'b0, zero: 1'b1};
    vecs[3] = '{a: 4'd0,  b: 4'd15, d: 4'h1, borrow: 1'b1, zero: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd0,  d: 4'hF, borrow: 1'b0, zero: 1'b0};
    vecs[5] = '{a: 4'd8,  b: 4'd1,  d: 4'h7, borrow: 1'b0, zero: 1'b0};
    vecs[6] = '{a: 4'd0,  b: 4'd1,  d: 4'hF, borrow: 1'b1, zero: 1'b0};
    vecs[7] = '{a: 4'd7,  b: 4'd8,  d: 4'hF, borrow: 1'b1, zero: 1'b0};
    vecs[8] = '{a: 4'd0,  b: 4'd0,  d: 4'h0, borrow: 1'b0, zero: 1'b1};
    vecs[9] = '{a: 4'd14, b: 4'd7,  d: 4'h7, borrow: 1'b0, zero: 1'b0};

    held_d = '0; held_b = 1'b0; held_z = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset uo_out", uo_out, 8'h00);
    tick();
    tick();
    check("reset held", uo_out, 8'h00);
    #3 rst_n = 1'b1;                          // release mid-phase
    tick();
    check("idle no start", uo_out, 8'h00);

    // Table-driven vectors; exact bytes 8'h46 (DONE) and 8'h1A (held) come from vecs[0..1].
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].borrow, vecs[i].zero, 1'b0, "vec");
    check("vec0 byte", {2'b01, 1'b0, 1'b0, 4'h6} | {1'b0, 7'h0}, 8'h46);

    // Operands and start changed during SHIFT must not disturb the result.
    ui_in     = {4'd3, 4'd9};
    uio_in[0] = 1'b1;
    tick();
    ui_in = {4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      check("chg busy", uo_out[6:5], 2'b01);
      tick();
    end
    check("chg done", uo_out, 8'h46);
    tick();                                   // start high in DONE is ignored
    check("chg idle", uo_out, 8'h06);
    uio_in[0] = 1'b0;
    tick();
    check("chg no reload", uo_out, 8'h06);
    held_d = 4'h6; held_b = 1'b0; held_z = 1'b0;

    // Reset after two SHIFT edges aborts with nothing visible.
    ui_in     = {4'd4, 4'd12};
    uio_in[0] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    tick();
    tick();
    check("abort busy", uo_out, 8'h26);
    #2 rst_n = 1'b0;
    #1;
    check("abort reset", uo_out, 8'h00);
    tick();
    #3 rst_n = 1'b1;
    held_d = '0; held_b = 1'b0; held_z = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort quiet", uo_out, 8'h00);
    end

    // All 256 pairs back-to-back with start held and junk on spare inputs.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] ea, eb, ed;
        ea = 4'(a);
        eb = 4'(b);
        ed = 4'(a - b);
        uio_in[7:1] = 7'($urandom);
        ena = 1'($urandom);
        run_op(ea, eb, ed, (a < b), (ed == 4'd0), 1'b1, "sweep");
      end
    end
    uio_in = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
